// File: rtl/motor_drive_pkg.sv
// Shared types and helpers for the two-channel motor drive: signed wheel
// speeds, PWM magnitudes, channel FSM states and the speed clamp/magnitude
// helpers used by each channel.
package motor_drive_pkg;

    typedef logic signed [9:0] speed_t;
    typedef logic        [8:0] mag_t;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } chan_state_t;

    localparam int     SPEED_MAX       = 511;
    localparam speed_t SPEED_NEG_LIMIT = speed_t'(-SPEED_MAX);
    localparam speed_t SPEED_RAW_MIN   = 10'b10_0000_0000;
    localparam speed_t SPEED_ZERO      = 10'sd0;

    // The most negative code has no positive twin, so fold it onto -511.
    function automatic speed_t clamp_speed(input speed_t raw);
        speed_t res;
        if (raw == SPEED_RAW_MIN) begin
            res = SPEED_NEG_LIMIT;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    // Unsigned magnitude of an already clamped speed.
    function automatic mag_t speed_mag(input speed_t s);
        mag_t m;
        if (s[9]) begin
            m = mag_t'(-s);
        end else begin
            m = mag_t'(s);
        end
        return m;
    endfunction

endpackage

// File: rtl/motor_drive_if.sv
// Bundle between the balance control loop and the motor drive: enable and
// wheel speed commands towards the drive, H-bridge pins and status back.
interface motor_drive_if;
    import motor_drive_pkg::*;

    logic   enable;
    speed_t target_speed_left;
    speed_t target_speed_right;
    logic   pwm_left;
    logic   dir_left;
    logic   pwm_right;
    logic   dir_right;
    speed_t cur_speed_left;
    speed_t cur_speed_right;
    logic   period_start;

    modport master (
        output enable,
        output target_speed_left,
        output target_speed_right,
        input  pwm_left,
        input  dir_left,
        input  pwm_right,
        input  dir_right,
        input  cur_speed_left,
        input  cur_speed_right,
        input  period_start
    );

    modport slave (
        input  enable,
        input  target_speed_left,
        input  target_speed_right,
        output pwm_left,
        output dir_left,
        output pwm_right,
        output dir_right,
        output cur_speed_left,
        output cur_speed_right,
        output period_start
    );

endinterface

// File: rtl/motor_drive_channel.sv
// One H-bridge channel: slew-limited speed ramp, reversal through zero and a
// dead-time with PWM low, then the direction flip. All speed updates happen
// on the shared period_start strobe; PWM is a registered magnitude compare.
module motor_channel
    import motor_drive_pkg::*;
#(
    parameter int PWM_BITS     = 9,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                period_start,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  speed_t              target_speed,
    output logic                pwm,
    output logic                dir,
    output speed_t              cur_speed
);

    localparam int DEAD_LOAD_INT = (DEAD_PERIODS > 0) ? DEAD_PERIODS : 1;
    localparam int DEAD_W        = (DEAD_LOAD_INT > 1) ? $clog2(DEAD_LOAD_INT + 1) : 1;
    localparam int CMP_W         = (PWM_BITS > 9) ? PWM_BITS : 9;

    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_LOAD_INT);
    localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
    localparam logic [DEAD_W-1:0] DEAD_ZERO = DEAD_W'(0);

    localparam logic signed [10:0] STEP_POS = 11'(RAMP_STEP);
    localparam logic signed [10:0] STEP_NEG = -STEP_POS;
    localparam speed_t             STEP_S10 = speed_t'(RAMP_STEP);

    chan_state_t        state_r;
    chan_state_t        state_next_s;
    logic [DEAD_W-1:0]  dead_cnt_r;
    logic [DEAD_W-1:0]  dead_cnt_next_s;
    logic               dir_r;
    logic               dir_next_s;
    logic               pwm_r;
    logic               pwm_next_s;
    speed_t             cur_r;
    speed_t             cur_next_s;

    speed_t             tgt_s;
    logic signed [10:0] tgt_ext_s;
    logic signed [10:0] cur_ext_s;
    logic signed [10:0] diff_s;
    speed_t             ramp_up_s;
    speed_t             ramp_dn_s;
    speed_t             ramped_s;
    speed_t             to_zero_s;
    logic               tgt_neg_s;
    logic               tgt_pos_s;
    logic               opposes_s;
    mag_t               mag_next_s;

    // Ramp arithmetic: 11-bit differences so +/-511 never overflows; the
    // 10-bit step sums are only selected where they stay in range.
    always_comb begin
        tgt_s     = clamp_speed(target_speed);
        tgt_ext_s = {tgt_s[9], tgt_s};
        cur_ext_s = {cur_r[9], cur_r};
        diff_s    = tgt_ext_s - cur_ext_s;
        ramp_up_s = cur_r + STEP_S10;
        ramp_dn_s = cur_r - STEP_S10;
        tgt_neg_s = tgt_s[9];
        tgt_pos_s = ~tgt_s[9] & (tgt_s != SPEED_ZERO);
        opposes_s = dir_r ? tgt_neg_s : tgt_pos_s;

        if (diff_s > STEP_POS) begin
            ramped_s = ramp_up_s;
        end else if (diff_s < STEP_NEG) begin
            ramped_s = ramp_dn_s;
        end else begin
            ramped_s = tgt_s;
        end

        if (cur_ext_s > STEP_POS) begin
            to_zero_s = ramp_dn_s;
        end else if (cur_ext_s < STEP_NEG) begin
            to_zero_s = ramp_up_s;
        end else begin
            to_zero_s = SPEED_ZERO;
        end
    end

    // Channel FSM next state: ramp in RUN, count out the dead-time in DEAD.
    always_comb begin
        state_next_s    = state_r;
        dead_cnt_next_s = dead_cnt_r;
        dir_next_s      = dir_r;
        cur_next_s      = cur_r;
        if (!enable) begin
            state_next_s    = RUN;
            dead_cnt_next_s = DEAD_ZERO;
            cur_next_s      = SPEED_ZERO;
        end else if (period_start) begin
            case (state_r)
                RUN: begin
                    if (!opposes_s) begin
                        cur_next_s = ramped_s;
                    end else if (cur_r != SPEED_ZERO) begin
                        cur_next_s = to_zero_s;
                    end else begin
                        state_next_s    = DEAD;
                        dead_cnt_next_s = DEAD_LOAD;
                    end
                end
                DEAD: begin
                    cur_next_s = SPEED_ZERO;
                    if (dead_cnt_r <= DEAD_ONE) begin
                        dead_cnt_next_s = DEAD_ZERO;
                        dir_next_s      = ~dir_r;
                        state_next_s    = RUN;
                    end else begin
                        dead_cnt_next_s = dead_cnt_r - DEAD_ONE;
                    end
                end
                default: begin
                    state_next_s    = RUN;
                    dead_cnt_next_s = DEAD_ZERO;
                    cur_next_s      = SPEED_ZERO;
                end
            endcase
        end else begin
            cur_next_s = cur_r;
        end
    end

    // PWM compare against the speed being loaded this clock, so a new speed
    // applies from the first count of its period.
    always_comb begin
        mag_next_s = speed_mag(cur_next_s);
        if (!enable || (state_next_s == DEAD)) begin
            pwm_next_s = 1'b0;
        end else begin
            pwm_next_s = (CMP_W'(pwm_cnt) < CMP_W'(mag_next_s));
        end
    end

    // Channel state, direction, applied speed and PWM pin registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= RUN;
            dead_cnt_r <= DEAD_ZERO;
            dir_r      <= 1'b1;
            cur_r      <= SPEED_ZERO;
            pwm_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            dead_cnt_r <= dead_cnt_next_s;
            dir_r      <= dir_next_s;
            cur_r      <= cur_next_s;
            pwm_r      <= pwm_next_s;
        end
    end

    assign pwm       = pwm_r;
    assign dir       = dir_r;
    assign cur_speed = cur_r;

endmodule

// File: rtl/motor_drive.sv
// Two-wheel motor drive: a shared PWM timebase (prescaler, period counter,
// period_start strobe) feeding two independent slew-limited channels.
module motor_drive
    import motor_drive_pkg::*;
#(
    parameter int PWM_BITS     = 9,
    parameter int CLK_DIV      = 4,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 2
) (
    input  logic         clock,
    input  logic         reset,
    motor_drive_if.slave bus
);

    localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [PRESC_W-1:0]  PRESC_ZERO = PRESC_W'(0);
    localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);
    localparam logic [PWM_BITS-1:0] CNT_LAST   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] CNT_ZERO   = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] CNT_ONE    = PWM_BITS'(1);

    logic [PRESC_W-1:0]  presc_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic                period_start_r;
    logic                presc_wrap_s;

    assign presc_wrap_s = (presc_r == PRESC_LAST);

    // Free-running timebase; period_start is registered so it is high while
    // presc and pwm_cnt both sit at zero, starting one full period after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_r        <= PRESC_ZERO;
            pwm_cnt_r      <= CNT_ZERO;
            period_start_r <= 1'b0;
        end else begin
            if (presc_wrap_s) begin
                presc_r   <= PRESC_ZERO;
                pwm_cnt_r <= pwm_cnt_r + CNT_ONE;
            end else begin
                presc_r   <= presc_r + PRESC_ONE;
                pwm_cnt_r <= pwm_cnt_r;
            end
            period_start_r <= presc_wrap_s && (pwm_cnt_r == CNT_LAST);
        end
    end

    assign bus.period_start = period_start_r;

    motor_channel #(
        .PWM_BITS    (PWM_BITS),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_PERIODS(DEAD_PERIODS)
    ) u_left (
        .clock       (clock),
        .reset       (reset),
        .enable      (bus.enable),
        .period_start(period_start_r),
        .pwm_cnt     (pwm_cnt_r),
        .target_speed(bus.target_speed_left),
        .pwm         (bus.pwm_left),
        .dir         (bus.dir_left),
        .cur_speed   (bus.cur_speed_left)
    );

    motor_channel #(
        .PWM_BITS    (PWM_BITS),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_PERIODS(DEAD_PERIODS)
    ) u_right (
        .clock       (clock),
        .reset       (reset),
        .enable      (bus.enable),
        .period_start(period_start_r),
        .pwm_cnt     (pwm_cnt_r),
        .target_speed(bus.target_speed_right),
        .pwm         (bus.pwm_right),
        .dir         (bus.dir_right),
        .cur_speed   (bus.cur_speed_right)
    );

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive. The prescaler is set to 2 so the right
// channel can ramp all the way to the -511 clamp within the run; expected
// PWM high times scale as |speed| * CLK_DIV clocks per period.
module tb_motor_drive;
    import motor_drive_pkg::*;

    localparam int PWM_BITS     = 9;
    localparam int CLK_DIV      = 2;
    localparam int RAMP_STEP    = 8;
    localparam int DEAD_PERIODS = 2;
    localparam int PERIOD       = CLK_DIV * (1 << PWM_BITS);

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   c;
    int   hl;
    int   hr;
    int   rev_exp [3] = '{12, 4, 0};

    motor_drive_if bus();

    motor_drive #(
        .PWM_BITS    (PWM_BITS),
        .CLK_DIV     (CLK_DIV),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_PERIODS(DEAD_PERIODS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic signed [31:0] got,
                               input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Waits (bounded) for the next period_start, sampling on falling edges.
    task automatic wait_ps(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (bus.period_start !== 1'b1 && cycles < 2 * PERIOD);
        check_value("period_start_seen", bus.period_start, 1);
    endtask

    // Moves to one clock after the next period_start, when updates are visible.
    task automatic next_period();
        int k;
        wait_ps(k);
        @(negedge clock);
    endtask

    // Called at the period_start clock; counts PWM high clocks over one period.
    task automatic measure(output int l, output int r);
        l = 0;
        r = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge clock);
            l = l + int'(bus.pwm_left);
            r = r + int'(bus.pwm_right);
        end
    endtask

    initial begin
        reset                  = 1'b1;
        bus.enable             = 1'b1;
        bus.target_speed_left  = 10'sd100;
        bus.target_speed_right = 10'b10_0000_0000;
        repeat (3) @(negedge clock);
        check_value("rst_cur_left", bus.cur_speed_left, 0);
        check_value("rst_dir_left", bus.dir_left, 1);
        check_value("rst_pwm_left", bus.pwm_left, 0);
        check_value("rst_dir_right", bus.dir_right, 1);
        check_value("rst_period_start", bus.period_start, 0);
        reset = 1'b0;

        // Ramp left to +100 while right heads for the -512 clamp via DEAD.
        for (int i = 1; i <= 12; i++) begin
            if (i == 1) begin
                wait_ps(c);
                check_value("first_ps_latency", c, PERIOD);
                @(negedge clock);
            end else begin
                next_period();
            end
            check_value("ramp_left", bus.cur_speed_left, (8 * i < 100) ? 8 * i : 100);
            check_value("right_cur", bus.cur_speed_right, (i <= 3) ? 0 : -8 * (i - 3));
            check_value("right_dir", bus.dir_right, (i < 3) ? 1 : 0);
        end
        wait_ps(c);
        measure(hl, hr);
        check_value("ramp_left_final", bus.cur_speed_left, 100);
        check_value("ramp_pwm_high_left", hl, 100 * CLK_DIV);
        check_value("ramp_dir_left", bus.dir_left, 1);
        check_value("right_cur_p13", bus.cur_speed_right, -80);
        check_value("right_pwm_high_p13", hr, 80 * CLK_DIV);

        // Back down to +20, then reverse to -20 through the dead-time.
        bus.target_speed_left = 10'sd20;
        repeat (10) next_period();
        check_value("ramp_down_left", bus.cur_speed_left, 20);
        bus.target_speed_left = -10'sd20;
        for (int i = 0; i < 3; i++) begin
            next_period();
            check_value("rev_to_zero", bus.cur_speed_left, rev_exp[i]);
            check_value("rev_dir_hold", bus.dir_left, 1);
        end
        next_period();
        check_value("dead_enter_cur", bus.cur_speed_left, 0);
        check_value("dead_enter_dir", bus.dir_left, 1);
        wait_ps(c);
        measure(hl, hr);
        check_value("dead_pwm_high", hl, 0);
        check_value("dead_dir_still", bus.dir_left, 1);
        next_period();
        check_value("dead_exit_dir", bus.dir_left, 0);
        check_value("dead_exit_cur", bus.cur_speed_left, 0);
        for (int i = 1; i <= 3; i++) begin
            next_period();
            check_value("rev_ramp", bus.cur_speed_left, (i < 3) ? -8 * i : -20);
            check_value("rev_ramp_dir", bus.dir_left, 0);
        end

        // Return to zero, then a pulse on the target that misses period_start.
        bus.target_speed_left = 10'sd0;
        repeat (3) next_period();
        check_value("left_to_zero", bus.cur_speed_left, 0);
        repeat (100) @(negedge clock);
        bus.target_speed_left = -10'sd50;
        repeat (200) @(negedge clock);
        check_value("mid_period_hold", bus.cur_speed_left, 0);
        bus.target_speed_left = 10'sd0;
        wait_ps(c);
        measure(hl, hr);
        check_value("mid_period_pwm", hl, 0);
        next_period();
        check_value("mid_period_cur", bus.cur_speed_left, 0);
        check_value("mid_period_dir", bus.dir_left, 0);

        // Reverse left back to forward and ramp to +64.
        bus.target_speed_left = 10'sd64;
        repeat (3) next_period();
        check_value("rev2_dir", bus.dir_left, 1);
        check_value("rev2_cur", bus.cur_speed_left, 0);
        repeat (8) next_period();
        check_value("left_at_64", bus.cur_speed_left, 64);

        // Right settles on the clamp after 67 periods.
        repeat (19) next_period();
        check_value("clamp_right_cur", bus.cur_speed_right, -511);
        wait_ps(c);
        measure(hl, hr);
        check_value("clamp_pwm_high_right", hr, 511 * CLK_DIV);
        check_value("clamp_dir_right", bus.dir_right, 0);
        check_value("left64_pwm_high", hl, 64 * CLK_DIV);

        // Enable drop mid-period while both PWMs are high.
        next_period();
        repeat (20) @(negedge clock);
        check_value("pre_drop_pwm_left", bus.pwm_left, 1);
        check_value("pre_drop_pwm_right", bus.pwm_right, 1);
        bus.enable = 1'b0;
        @(negedge clock);
        check_value("drop_cur_left", bus.cur_speed_left, 0);
        check_value("drop_pwm_left", bus.pwm_left, 0);
        check_value("drop_dir_left", bus.dir_left, 1);
        check_value("drop_cur_right", bus.cur_speed_right, 0);
        check_value("drop_pwm_right", bus.pwm_right, 0);
        check_value("drop_dir_right", bus.dir_right, 0);
        next_period();
        check_value("drop_hold_cur", bus.cur_speed_left, 0);
        bus.enable = 1'b1;
        next_period();
        check_value("reen_left_8", bus.cur_speed_left, 8);
        check_value("reen_right_m8", bus.cur_speed_right, -8);
        next_period();
        check_value("reen_left_16", bus.cur_speed_left, 16);

        // Drive left into DEAD, then reset asynchronously in the middle of it.
        bus.target_speed_left = -10'sd30;
        repeat (3) next_period();
        check_value("pre_rst_cur", bus.cur_speed_left, 0);
        check_value("pre_rst_right", bus.cur_speed_right, -40);
        repeat (50) @(negedge clock);
        check_value("pre_rst_pwm_right", bus.pwm_right, 1);
        reset = 1'b1;
        #1;
        check_value("arst_cur_left", bus.cur_speed_left, 0);
        check_value("arst_dir_left", bus.dir_left, 1);
        check_value("arst_cur_right", bus.cur_speed_right, 0);
        check_value("arst_dir_right", bus.dir_right, 1);
        check_value("arst_pwm_right", bus.pwm_right, 0);
        check_value("arst_period_start", bus.period_start, 0);
        @(negedge clock);
        reset = 1'b0;
        wait_ps(c);
        check_value("ps_after_reset", c, PERIOD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/motor_drive.md
Name: motor_drive

Overview:
- Consumes the signed wheel speed commands from the balance control loop (target_speed_left, target_speed_right) and produces PWM and direction pins for the two H-bridge motor channels.
- Each channel is slew-rate limited, with one ramp step per PWM period.
- A reversal first ramps the channel to zero, then holds a dead-time with PWM forced low, then flips the direction pin.
- Sits between the control loop and the motor driver pins.

Parameters:
- PWM_BITS, 9: PWM counter width. Period is 2^PWM_BITS counts. Duty resolution matches the 9-bit speed magnitude.
- CLK_DIV, 4: number of clocks per PWM count (prescaler). Period = CLK_DIV*2^PWM_BITS clocks.
- RAMP_STEP, 8: maximum change of current speed per PWM period, in speed units.
- DEAD_PERIODS, 2: number of full PWM periods with PWM low before a direction flip.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  motor enable. Low forces the outputs idle.
- target_speed_left  in  10  signed left wheel target speed (two's complement)
- target_speed_right  in  10  signed right wheel target speed
- pwm_left  out  1  left PWM, registered
- dir_left  out  1  left direction: 1 = forward (speed >= 0), 0 = reverse
- pwm_right  out  1  right PWM, registered
- dir_right  out  1  right direction
- cur_speed_left  out  10  signed ramped speed currently applied, left
- cur_speed_right  out  10  signed ramped speed currently applied, right
- period_start  out  1  one-clock pulse on the first clock of each PWM period

Behaviour:
- Reset values:
  - presc=0, pwm_cnt=0
  - cur_speed_*=0, dir_*=1, pwm_*=0, period_start=0
  - channel state=RUN, dead counter=0
- Timebase, shared by both channels:
  - presc counts 0..CLK_DIV-1 and wraps.
  - pwm_cnt increments when presc wraps, and wraps from 2^PWM_BITS-1 to 0.
  - period_start=1 for exactly the clock on which presc==0 and pwm_cnt==0.
  - Counters run regardless of enable.
- Target sampling:
  - Targets are read only on period_start; changes mid-period are ignored.
  - Sampled value is clamped to [-511,+511], so -512 becomes -511.
- Channel FSM, states RUN and DEAD. All updates occur on period_start unless noted.
  - RUN, target sign agrees with dir, or target==0:
    - cur moves toward target by min(|target-cur|, RAMP_STEP).
  - RUN, target sign opposes dir:
    - If cur!=0, cur moves toward 0 by min(|cur|, RAMP_STEP) and never crosses zero.
    - If cur==0, go to DEAD and load the dead counter with DEAD_PERIODS.
  - DEAD:
    - cur is held at 0 and pwm is held low.
    - The counter decrements on each period_start.
    - On the period_start where the counter reaches 0: flip dir, go to RUN. cur stays 0; ramping resumes on the following period_start.
  - Sign convention: positive target vs dir=1 agrees; negative target vs dir=0 agrees. After reset dir=1, so a first negative target passes through DEAD.
- PWM output:
  - Next-state value is pwm_cnt < |cur|. Output is registered, so the pin lags the counter by 1 clock.
  - |cur|=0 gives always low. |cur|=511 gives high for 511 of 512 counts.
  - The magnitude comparison uses the live cur, so a new cur takes effect from the first count of the period.
- enable=0:
  - On the next clock: cur=0, pwm=0, state=RUN, dead counter=0. dir is retained.
  - On re-enable, ramping restarts from 0 at the next period_start.
- Arithmetic:
  - Differences are computed 11-bit signed, so there is no overflow at ±511.
  - Magnitude is 9-bit unsigned.
- Independence:
  - Channels are fully independent and share only the timebase.
  - Simultaneous reversal on both channels is legal.
- Reset asserted mid-ramp or in DEAD returns all registers to their reset values immediately (asynchronous).

Decomposition:
- Package motor_drive_pkg contains:
  - typedef speed_t: logic signed [9:0]
  - typedef mag_t: logic [8:0]
  - enum chan_state_t {RUN, DEAD}
  - constant SPEED_MAX=511
- Sub-module motor_channel, instantiated twice. It holds the ramp, FSM, dead counter and PWM compare for one wheel.
- The top holds the prescaler, pwm_cnt and period_start, and the two instances.

Test Plan:
- Ramp up: from reset, target_left=+100 -> cur_speed_left steps 8,16,...,96,100 over 13 periods. In the 13th period pwm_left is high for 100*CLK_DIV=400 clocks; dir_left=1.
- Reversal: cur=+20, target=-20 -> cur steps 12,4,0, then 2 periods of DEAD with pwm=0 and dir=1. Then dir=0 and cur steps -8,-16,-20.
- Clamp and full duty: target=-512 -> cur settles at -511; pwm high 511*4 clocks per 2048-clock period; dir=0 after the dead-time.
- Mid-period change: target changes 0→+50 and back to 0 within one period, not spanning period_start -> cur stays 0 and pwm stays low.
- Enable drop: cur=+64 ramping, enable=0 -> next clock cur=0, pwm=0, dir=1. Re-enable with target=+64 -> ramp resumes 8,16,...
- Reset mid-DEAD: assert reset during DEAD -> all outputs at reset values within the same cycle, dir=1, period_start resumes 2048 clocks after release.
